cordic_pipe_reg: RTL and testbench

Parametrised elastic pipeline register for the CORDIC calculator datapath. It generalises the single 6-bit synchronous-reset register into a chain of DEPTH stages of WIDTH bits, with a per-stage valid bit, valid/ready backpressure, bubble collapsing, a flush input and an occupancy count. It sits between CORDIC iteration stages and between the datapath and the result/display logic wherever a stallable delay is needed.

---
 rtl/cordic_pipe_reg.sv | 95 +++++++++
 tb/tb_cordic_pipe_reg.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cordic_pipe_reg.sv
// Elastic DEPTH-stage pipeline register for the CORDIC datapath.
// Per-stage valid bits, valid/ready backpressure with bubble collapse, flush and occupancy count.
module cordic_pipe_reg #(
  parameter int               WIDTH   = 6,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              CW      = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic [CW-1:0]    COUNT
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] d_q   [DEPTH];
  logic [WIDTH-1:0] d_d   [DEPTH];
  logic [WIDTH-1:0] src_d [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] vec);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vec[i]) c = c + CW'(1);
    end
    return c;
  endfunction

  // Ready ripples from the output backwards; a running scalar keeps the chain acyclic.
  always_comb begin : ready_chain
    logic a;
    a   = !v_q[DEPTH-1] || OUT_READY;
    adv = '0;
    adv[DEPTH-1] = a;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      a      = !v_q[i] || a;
      adv[i] = a;
    end
  end

  always_comb begin : stage_sources
    src_v    = '0;
    src_v[0] = IN_VALID;
    src_d[0] = IN_DATA;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = v_q[i-1];
      src_d[i] = d_q[i-1];
    end
  end

  always_comb begin : next_state
    v_d = v_q;
    for (int i = 0; i < DEPTH; i++) begin
      d_d[i] = d_q[i];
      if (adv[i]) begin
        v_d[i] = src_v[i];
        if (src_v[i]) d_d[i] = src_d[i];
      end
    end
    count_d = popcount(v_d);
  end

  // Reset wins over flush; flush drops valid bits but keeps data registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= RST_VAL;
    end else if (FLUSH) begin
      v_q     <= '0;
      count_q <= '0;
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= d_d[i];
    end
  end

  assign IN_READY  = adv[0] && !FLUSH;
  assign OUT_VALID = v_q[DEPTH-1] && !FLUSH;
  assign OUT_DATA  = d_q[DEPTH-1];
  assign COUNT     = count_q;

endmodule

// File: tb/tb_cordic_pipe_reg.sv
// Directed bench for cordic_pipe_reg: a DEPTH=4 instance plus a DEPTH=1 instance
// sharing the same stimulus; expected values are hand-derived per step.
module tb_cordic_pipe_reg;

  logic       CLK;
  logic       RST;
  logic       FLUSH;
  logic       IN_VALID;
  logic       IN_READY;
  logic [5:0] IN_DATA;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [5:0] OUT_DATA;
  logic [2:0] COUNT;

  logic       in_ready1;
  logic       out_valid1;
  logic [5:0] out_data1;
  logic       count1;

  int n_tests = 0;
  int n_fail  = 0;

  cordic_pipe_reg #(.WIDTH(6), .DEPTH(4), .RST_VAL(6'h15)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .COUNT(COUNT)
  );

  cordic_pipe_reg #(.WIDTH(6), .DEPTH(1), .RST_VAL(6'h00)) dut1 (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(in_ready1), .IN_DATA(IN_DATA),
    .OUT_VALID(out_valid1), .OUT_READY(OUT_READY), .OUT_DATA(out_data1),
    .COUNT(count1)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b1; IN_DATA = 6'h3F; OUT_READY = 1'b1;

    // reset held two cycles with a word offered
    tick;
    tick;
    check("rst_out_data", OUT_DATA, 32'h15);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_count", COUNT, 0);
    check("rst_d1_out_data", out_data1, 0);
    RST = 1'b0;
    #1;
    check("rst_in_ready", IN_READY, 1);

    // streaming 1..10, OUT_READY held high
    for (int c = 0; c < 14; c++) begin
      IN_VALID = (c < 10);
      IN_DATA  = 6'(c + 1);
      tick;
      check($sformatf("stream_valid_%0d", c), OUT_VALID, (c >= 3 && c <= 12) ? 1 : 0);
      if (c >= 3 && c <= 12) check($sformatf("stream_data_%0d", c), OUT_DATA, 32'(c - 2));
      if (c >= 3 && c <= 9) check($sformatf("stream_count_%0d", c), COUNT, 4);
      if (c < 10) begin
        check($sformatf("d1_data_%0d", c), out_data1, 32'(c + 1));
        check($sformatf("d1_valid_%0d", c), out_valid1, 1);
      end
    end
    check("stream_drained", COUNT, 0);

    // backpressure: five words offered into a stalled pipe
    OUT_READY = 1'b0;
    IN_VALID  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      IN_DATA = 6'(c + 33);
      #1;
      check($sformatf("bp_in_ready_%0d", c), IN_READY, 1);
      tick;
    end
    check("bp_full_count", COUNT, 4);
    check("bp_full_valid", OUT_VALID, 1);
    check("bp_full_data", OUT_DATA, 32'h21);
    IN_DATA = 6'h25;
    #1;
    check("bp_5th_blocked", IN_READY, 0);
    tick;
    check("bp_hold_count", COUNT, 4);
    check("bp_hold_data", OUT_DATA, 32'h21);
    OUT_READY = 1'b1;
    #1;
    check("bp_release_ready", IN_READY, 1);
    tick;
    IN_VALID = 1'b0;
    check("bp_after_swap_data", OUT_DATA, 32'h22);
    check("bp_after_swap_count", COUNT, 4);
    for (int w = 8'h23; w <= 8'h25; w++) begin
      tick;
      check($sformatf("bp_order_%0h", w), OUT_DATA, 32'(w));
      check($sformatf("bp_valid_%0h", w), OUT_VALID, 1);
    end
    tick;
    check("bp_empty_valid", OUT_VALID, 0);
    check("bp_empty_count", COUNT, 0);

    // bubble collapse: A, three idle cycles, B, output stalled
    OUT_READY = 1'b0;
    IN_VALID = 1'b1; IN_DATA = 6'h0A;
    tick;
    IN_VALID = 1'b0;
    tick; tick; tick;
    IN_VALID = 1'b1; IN_DATA = 6'h0B;
    tick;
    IN_VALID = 1'b0;
    check("bub_count_entry", COUNT, 2);
    tick; tick;
    check("bub_count", COUNT, 2);
    check("bub_v3", dut.v_q[3], 1);
    check("bub_v2", dut.v_q[2], 1);
    check("bub_a_out", OUT_DATA, 32'h0A);
    OUT_READY = 1'b1;
    tick;
    check("bub_b_out", OUT_DATA, 32'h0B);
    check("bub_b_valid", OUT_VALID, 1);
    tick;
    check("bub_empty", OUT_VALID, 0);

    // flush with three words inside and a word offered
    OUT_READY = 1'b0;
    IN_VALID = 1'b1;
    for (int c = 0; c < 3; c++) begin
      IN_DATA = 6'(c + 49);
      tick;
    end
    IN_VALID = 1'b0;
    tick;
    check("fl_pre_count", COUNT, 3);
    check("fl_pre_valid", OUT_VALID, 1);
    check("fl_pre_data", OUT_DATA, 32'h31);
    FLUSH = 1'b1; IN_VALID = 1'b1; IN_DATA = 6'h3F; OUT_READY = 1'b1;
    #1;
    check("fl_in_ready", IN_READY, 0);
    check("fl_out_valid", OUT_VALID, 0);
    tick;
    FLUSH = 1'b0; IN_VALID = 1'b0;
    check("fl_count", COUNT, 0);
    check("fl_valid", OUT_VALID, 0);
    check("fl_data_held", OUT_DATA, 32'h31);
    tick;
    check("fl_nothing_taken", COUNT, 0);

    // reset and flush together mid-stream
    OUT_READY = 1'b0;
    IN_VALID = 1'b1; IN_DATA = 6'h11;
    tick;
    IN_DATA = 6'h12;
    tick;
    check("rf_pre_count", COUNT, 2);
    RST = 1'b1; FLUSH = 1'b1; IN_DATA = 6'h2A;
    tick;
    RST = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0;
    check("rf_data", OUT_DATA, 32'h15);
    check("rf_count", COUNT, 0);
    check("rf_valid", OUT_VALID, 0);
    check("rf_d1_data", out_data1, 0);
    tick;
    check("rf_stay_empty", COUNT, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
